// File: rtl/sdram_p0_line_buffer.sv
// Single-line read buffer with write-through in front of sdram port 0.
// Reads hit one cached 8-word line; misses fetch it with one burst.
module sdram_p0_line_buffer #(
    parameter int ADDR_WIDTH = 25,
    parameter int LINE_WORDS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init_complete,
    input  logic [ADDR_WIDTH-1:0]   cl_addr,
    input  logic [15:0]             cl_wr_data,
    input  logic [1:0]              cl_byte_en,
    input  logic                    cl_wr,
    input  logic                    cl_rd,
    input  logic                    cl_flush,
    output logic [15:0]             cl_rd_data,
    output logic                    cl_rd_valid,
    output logic                    cl_busy,
    output logic [ADDR_WIDTH-1:0]   p0_addr,
    output logic [15:0]             p0_data,
    output logic [1:0]              p0_byte_en,
    output logic                    p0_wr_req,
    output logic                    p0_rd_req,
    input  logic                    p0_ready,
    input  logic [16*LINE_WORDS-1:0] p0_q
);

    localparam int OFF = $clog2(LINE_WORDS);
    localparam int TW  = ADDR_WIDTH - OFF;

    typedef enum logic [2:0] {
        INIT, IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP
    } state_t;

    state_t                  state_q;
    logic                    is_wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [15:0]             wdata_q;
    logic [1:0]              be_q;
    logic                    line_valid_q;
    logic [TW-1:0]           line_tag_q;
    logic [16*LINE_WORDS-1:0] line_data_q;

    logic [15:0]             rd_data_q;
    logic                    rd_valid_q;
    logic                    busy_q;
    logic [ADDR_WIDTH-1:0]   p0_addr_q;
    logic [15:0]             p0_data_q;
    logic [1:0]              p0_be_q;
    logic                    p0_wr_q;
    logic                    p0_rd_q;

    logic                    cl_hit;
    logic                    lat_hit;
    logic [OFF+3:0]          cl_sel;
    logic [OFF+3:0]          lat_sel;
    logic [15:0]             old_w;
    logic [15:0]             word_d;

    assign cl_hit  = line_valid_q && (line_tag_q == cl_addr[ADDR_WIDTH-1:OFF]);
    assign lat_hit = line_valid_q && (line_tag_q == addr_q[ADDR_WIDTH-1:OFF]);
    assign cl_sel  = {cl_addr[OFF-1:0], 4'b0000};
    assign lat_sel = {addr_q[OFF-1:0], 4'b0000};
    assign old_w   = line_data_q[lat_sel +: 16];

    // Byte-granular merge of the latched write into the cached word.
    assign word_d = {be_q[1] ? wdata_q[15:8] : old_w[15:8],
                     be_q[0] ? wdata_q[7:0]  : old_w[7:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= INIT;
            line_valid_q <= 1'b0;
            is_wr_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            busy_q       <= 1'b1;
            p0_addr_q    <= '0;
            p0_data_q    <= '0;
            p0_be_q      <= '0;
            p0_wr_q      <= 1'b0;
            p0_rd_q      <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            unique case (state_q)
                INIT: begin
                    if (init_complete && p0_ready) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (cl_flush) begin
                        line_valid_q <= 1'b0;
                    end else if (cl_wr) begin
                        addr_q  <= cl_addr;
                        wdata_q <= cl_wr_data;
                        be_q    <= cl_byte_en;
                        is_wr_q <= 1'b1;
                        state_q <= ISSUE;
                        busy_q  <= 1'b1;
                    end else if (cl_rd && cl_hit) begin
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= line_data_q[cl_sel +: 16];
                        state_q    <= RESP;
                        busy_q     <= 1'b1;
                    end else if (cl_rd) begin
                        addr_q  <= cl_addr;
                        is_wr_q <= 1'b0;
                        state_q <= ISSUE;
                        busy_q  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (is_wr_q) begin
                        p0_wr_q   <= 1'b1;
                        p0_addr_q <= addr_q;
                        p0_data_q <= wdata_q;
                        p0_be_q   <= be_q;
                    end else begin
                        p0_rd_q   <= 1'b1;
                        p0_addr_q <= {addr_q[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                        p0_data_q <= '0;
                        p0_be_q   <= 2'b11;
                    end
                    state_q <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!p0_ready) begin
                        p0_wr_q   <= 1'b0;
                        p0_rd_q   <= 1'b0;
                        p0_addr_q <= '0;
                        p0_data_q <= '0;
                        p0_be_q   <= '0;
                        state_q   <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (p0_ready) begin
                        if (is_wr_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            line_valid_q <= 1'b1;
                            rd_valid_q   <= 1'b1;
                            rd_data_q    <= p0_q[lat_sel +: 16];
                            state_q      <= RESP;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= INIT;
            endcase
        end
    end

    // Line contents and tag are qualified by line_valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        if (state_q == ISSUE && is_wr_q && lat_hit) begin
            line_data_q[lat_sel +: 16] <= word_d;
        end else if (state_q == WAIT_DONE && !is_wr_q && p0_ready) begin
            line_data_q <= p0_q;
            line_tag_q  <= addr_q[ADDR_WIDTH-1:OFF];
        end
    end

    assign cl_rd_data  = rd_data_q;
    assign cl_rd_valid = rd_valid_q;
    assign cl_busy     = busy_q;
    assign p0_addr     = p0_addr_q;
    assign p0_data     = p0_data_q;
    assign p0_byte_en  = p0_be_q;
    assign p0_wr_req   = p0_wr_q;
    assign p0_rd_req   = p0_rd_q;

endmodule

// File: doc/sdram_p0_line_buffer.md
# sdram_p0_line_buffer

Single-line read buffer with write-through, placed directly upstream of port 0 of the `sdram` controller. It accepts single 16-bit word reads and writes from a client and serves reads from one cached 8-word (128-bit) line. On a miss it fetches the line with one 8-beat burst over port 0. Every write is forwarded through port 0 as a single-word write. Port 0 is configured with `P0_BURST_LENGTH = 8`.

## Interface
- `ADDR_WIDTH`, 25: word address width. Matches `p0_addr`.
- `LINE_WORDS`, 8: words per line. Only 8 is supported; it must equal the controller's P0 burst length.
- `clk` in 1: single clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `init_complete` in 1: from the controller. No port-0 traffic is issued while it is low.
- `cl_addr` in 25: client word address.
- `cl_wr_data` in 16: client write data.
- `cl_byte_en` in 2: client byte enables. Bit 1 covers [15:8], bit 0 covers [7:0].
- `cl_wr` in 1: write strobe. Sampled only while `cl_busy` = 0.
- `cl_rd` in 1: read strobe. Sampled only while `cl_busy` = 0.
- `cl_flush` in 1: invalidates the line. Sampled only while `cl_busy` = 0.
- `cl_rd_data` out 16: read data. Valid only while `cl_rd_valid` = 1.
- `cl_rd_valid` out 1: one-cycle pulse per completed read.
- `cl_busy` out 1: high whenever the FSM is not in IDLE.
- `p0_addr` out 25, `p0_data` out 16, `p0_byte_en` out 2, `p0_wr_req` out 1, `p0_rd_req` out 1: drive the controller's port 0.
- `p0_ready` in 1: from the controller.
- `p0_q` in 128: from the controller. Word k of the line is `p0_q[16k+15:16k]`.

## Operation
- Held state:
  - `line_valid`
  - `line_tag` = address bits [24:3]
  - `line_data` (128 bits)
- Hit: `line_valid` = 1 and `line_tag` == `cl_addr[24:3]`. The word select is `cl_addr[2:0]`.
- FSM states: INIT, IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP.
- Reset:
  - State goes to INIT, `line_valid` = 0.
  - All outputs are 0, except `cl_busy` = 1.
  - `line_data` and `line_tag` are not reset.
- INIT → IDLE when `init_complete` = 1 and `p0_ready` = 1.
- IDLE, first match in priority order:
  1. `cl_flush`: clear `line_valid`. Stay in IDLE. Any strobes sampled that cycle are dropped.
  2. `cl_wr`: latch address, data and byte enables, then go to ISSUE(write).
  3. `cl_rd` with hit: go to RESP.
  4. `cl_rd` with miss: latch the address, then go to ISSUE(read).
- When `cl_wr` and `cl_rd` are both high, only the write is performed and the read is dropped.
- ISSUE(write):
  - `p0_wr_req` = 1, `p0_addr` = latched address, `p0_data` and `p0_byte_en` = latched values.
  - On a hit, merge the write into `line_data` byte-by-byte per `cl_byte_en` in the same cycle (write-through).
  - On a miss, leave the line unchanged (no allocate).
  - Go to WAIT_ACK.
- ISSUE(read):
  - `p0_rd_req` = 1, `p0_addr` = {latched[24:3], 3'b000}.
  - `p0_byte_en` = 2'b11, `p0_data` = 0.
  - Go to WAIT_ACK.
- WAIT_ACK:
  - Hold the request and all `p0_*` outputs stable until `p0_ready` = 0 is sampled.
  - Then drop the request to 0 and go to WAIT_DONE.
- WAIT_DONE, on `p0_ready` = 1:
  - Read: load `line_data` ← `p0_q`, `line_tag` ← latched[24:3], `line_valid` ← 1, then go to RESP.
  - Write: go to IDLE.
- RESP: `cl_rd_valid` = 1 and `cl_rd_data` = the selected word of `line_data` (after any fill), then go to IDLE.
- Outside ISSUE and WAIT_ACK, `p0_wr_req`, `p0_rd_req`, `p0_addr`, `p0_data` and `p0_byte_en` are 0.
- `cl_rd_data` is 0 whenever `cl_rd_valid` = 0.
- Reset in mid-operation: return to INIT in the next cycle and invalidate the line. The request in flight is abandoned; a partially completed transfer at the controller is tolerated.

## Timing
- `cl_busy` is registered. It rises the cycle after a write or read is accepted in IDLE and is low again on the cycle the FSM re-enters IDLE.
- Read hit: strobe sampled at edge N, `cl_rd_valid` high for cycle N+1, `cl_busy` high for that one cycle only.
- Read miss:
  - `p0_rd_req` rises at edge N+1.
  - `cl_rd_valid` is high in the cycle after the edge on which `p0_ready` = 1 is sampled in WAIT_DONE.
  - The total is the controller burst latency + 3 cycles.
- Write: `p0_wr_req` rises at edge N+1. The client may issue the next request one cycle after controller ready returns.
- The request to the controller is always held for at least one cycle and never for more than one cycle after `p0_ready` is seen low.

## Test plan
- After reset release and `init_complete`: write 0x1234 to 0x0322020 with byte_en 2'b11 → `p0_wr_req` pulse, `p0_addr` = 0x0322020, `p0_data` = 0x1234. The line stays invalid (miss write, no allocate).
- Write 0x5678…0x3210 to 0x0322021–0x0322027, then read 0x0322022 → one `p0_rd_req` with `p0_addr` = 0x0322020, then `cl_rd_data` = 0x9ABC.
- Back-to-back reads of 0x0322027 then 0x0322020 → no port-0 activity, `cl_rd_valid` one cycle after each strobe, data = 0x3210 then 0x1234.
- Write 0xAB00 with byte_en 2'b10 to 0x0322020 (hit), then read it → the port-0 write carries byte_en 2'b10, and the read returns 0xAB34 with no `p0_rd_req`.
- `cl_flush`, then read 0x0322020 → a fresh burst read is issued. `cl_rd` and `cl_wr` asserted together → only the write reaches port 0.
- Assert `reset` low during WAIT_DONE → in the next cycle all outputs are at their reset values and `cl_busy` = 1. After release, a read of 0x0322020 misses.
